vpu_tile_sched: RTL and testbench

Top-level sequencer for the tiled matrix-multiply vector unit. It walks C = A x B in T x T tiles: for each output tile (i,j) it iterates k, requesting A(i,k) and B(k,j) tile loads, issuing one MAC operation per k, then a C(i,j) store. It sits between the host start/done interface and the tile loader, the vector MAC datapath and the store path, and replaces free-running index counting with handshaked sequencing.

---
 rtl/vpu_tile_sched_pkg.sv | 33 +++
 rtl/vpu_tile_sched_counter.sv | 68 ++++++
 rtl/vpu_tile_sched.sv | 153 +++++++++++++++
 tb/tb_vpu_tile_sched.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_tile_sched_pkg.sv
// Shared types and constants for the tiled matrix-multiply sequencer.
// The default matrix and tile sizes come from the system configuration macros.
`ifndef ROW_M
`define ROW_M 8
`endif
`ifndef ROW_A
`define ROW_A 4
`endif

package vpu_pkg;

  localparam int M_DIM_DEF = `ROW_M;
  localparam int TILE_STEP = `ROW_A;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    MAC_ISSUE,
    MAC_WAIT,
    STORE,
    DONE
  } state_e;

  // Index width for a given matrix edge; never narrower than one bit.
  function automatic int idx_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/vpu_tile_sched_counter.sv
// Nested i/j/k tile index counter stepping by the tile edge.
// Wrap is tested against the last tile origin before adding, so no value exceeds M-T.
module vpu_tile_counter
  import vpu_pkg::*;
#(
  parameter int M_DIM = M_DIM_DEF,
  parameter int T_DIM = TILE_STEP,
  parameter int IDX_W = idx_w(M_DIM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_k,
  input  logic             inc_ij,
  input  logic             clr,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic [IDX_W-1:0] k,
  output logic             k_last,
  output logic             ij_last
);

  localparam logic [IDX_W-1:0] STEP = IDX_W'(T_DIM);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(M_DIM - T_DIM);

  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] k_q, k_d;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (inc_ij) begin
      k_d = '0;
      if (j_q != LAST) begin
        j_d = j_q + STEP;
      end else begin
        j_d = '0;
        if (i_q != LAST) i_d = i_q + STEP;
      end
    end else if (inc_k) begin
      k_d = k_q + STEP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign i       = i_q;
  assign j       = j_q;
  assign k       = k_q;
  assign k_last  = (k_q == LAST);
  assign ij_last = (i_q == LAST) && (j_q == LAST);

endmodule

// File: rtl/vpu_tile_sched.sv
// Handshaked sequencer walking C = A x B tile by tile: load A/B per k, MAC, then store C.
// Strobes and valids are registered from the next state; request fields follow the held indices.
module vpu_tile_sched
  import vpu_pkg::*;
#(
  parameter int M_DIM = M_DIM_DEF,
  parameter int T_DIM = TILE_STEP,
  parameter int IDX_W = idx_w(M_DIM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             ld_valid,
  output logic             ld_sel,
  output logic [IDX_W-1:0] ld_row,
  output logic [IDX_W-1:0] ld_col,
  input  logic             ld_ready,
  output logic             mac_start,
  output logic             acc_clr,
  input  logic             mac_done,
  output logic             st_valid,
  output logic [IDX_W-1:0] st_row,
  output logic [IDX_W-1:0] st_col,
  input  logic             st_ready
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   ld_valid_q, ld_valid_d;
  logic   ld_sel_q, ld_sel_d;
  logic   mac_start_q, mac_start_d;
  logic   acc_clr_q, acc_clr_d;
  logic   st_valid_q, st_valid_d;

  logic             inc_k, inc_ij, clr;
  logic [IDX_W-1:0] i, j, k;
  logic             k_last, ij_last;

  vpu_tile_counter #(
    .M_DIM(M_DIM),
    .T_DIM(T_DIM),
    .IDX_W(IDX_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc_k  (inc_k),
    .inc_ij (inc_ij),
    .clr    (clr),
    .i      (i),
    .j      (j),
    .k      (k),
    .k_last (k_last),
    .ij_last(ij_last)
  );

  always_comb begin
    state_d = state_q;
    inc_k   = 1'b0;
    inc_ij  = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_A;
          clr     = 1'b1;
        end
      end
      LOAD_A:    if (ld_valid_q && ld_ready) state_d = LOAD_B;
      LOAD_B:    if (ld_valid_q && ld_ready) state_d = MAC_ISSUE;
      MAC_ISSUE: state_d = MAC_WAIT;
      MAC_WAIT: begin
        if (mac_done) begin
          if (k_last) begin
            state_d = STORE;
          end else begin
            inc_k   = 1'b1;
            state_d = LOAD_A;
          end
        end
      end
      STORE: begin
        if (st_valid_q && st_ready) begin
          inc_ij  = 1'b1;
          state_d = ij_last ? DONE : LOAD_A;
        end
      end
      DONE: begin
        clr     = 1'b1;
        state_d = IDLE;
      end
      default: begin
        clr     = 1'b1;
        state_d = IDLE;
      end
    endcase
    // Cancel wins over any handshake completing in the same cycle.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      clr     = 1'b1;
      inc_k   = 1'b0;
      inc_ij  = 1'b0;
    end
  end

  always_comb begin
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    ld_valid_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
    ld_sel_d    = (state_d == LOAD_B) ? SEL_B : SEL_A;
    mac_start_d = (state_d == MAC_ISSUE);
    acc_clr_d   = (state_d == MAC_ISSUE) && (k == '0);
    st_valid_d  = (state_d == STORE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ld_valid_q  <= 1'b0;
      ld_sel_q    <= SEL_A;
      mac_start_q <= 1'b0;
      acc_clr_q   <= 1'b0;
      st_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ld_valid_q  <= ld_valid_d;
      ld_sel_q    <= ld_sel_d;
      mac_start_q <= mac_start_d;
      acc_clr_q   <= acc_clr_d;
      st_valid_q  <= st_valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ld_valid  = ld_valid_q;
  assign ld_sel    = ld_sel_q;
  assign ld_row    = (ld_sel_q == SEL_B) ? k : i;
  assign ld_col    = (ld_sel_q == SEL_B) ? j : k;
  assign mac_start = mac_start_q;
  assign acc_clr   = acc_clr_q;
  assign st_valid  = st_valid_q;
  assign st_row    = i;
  assign st_col    = j;

endmodule

// File: tb/tb_vpu_tile_sched.sv
// Bench for vpu_tile_sched: an 8x8/4 instance driven by a reactive responder and a 4x4/4 instance.
// Observed handshake streams are compared against the tile-walk order computed from loops.
module tb_vpu_tile_sched;

  logic       clk;
  logic       reset;
  logic       start, start_i, start_n;
  logic       abort;
  logic       busy, done, ld_valid, ld_sel, ld_ready;
  logic [2:0] ld_row, ld_col, st_row, st_col;
  logic       mac_start, acc_clr, mac_done, st_valid, st_ready;

  logic       start2, busy2, done2, ld_valid2, ld_sel2, mac_start2, acc_clr2, st_valid2;
  logic [1:0] ld_row2, ld_col2, st_row2, st_col2;
  logic       ld_ready2, mac_done2, st_ready2;

  assign start = start_i | start_n;

  vpu_tile_sched #(.M_DIM(8), .T_DIM(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_row(ld_row), .ld_col(ld_col), .ld_ready(ld_ready),
    .mac_start(mac_start), .acc_clr(acc_clr), .mac_done(mac_done),
    .st_valid(st_valid), .st_row(st_row), .st_col(st_col), .st_ready(st_ready)
  );

  vpu_tile_sched #(.M_DIM(4), .T_DIM(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(1'b0),
    .busy(busy2), .done(done2),
    .ld_valid(ld_valid2), .ld_sel(ld_sel2), .ld_row(ld_row2), .ld_col(ld_col2), .ld_ready(ld_ready2),
    .mac_start(mac_start2), .acc_clr(acc_clr2), .mac_done(mac_done2),
    .st_valid(st_valid2), .st_row(st_row2), .st_col(st_col2), .st_ready(st_ready2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Responder controls and observations.
  bit rnd = 0, noise = 0, st_block = 0, sn_done = 0;
  int stall_cnt = 0, stall_seen = 0, stall_bad = 0, hold_err = 0;
  int n_st = 0, done_cnt = 0, done_cyc = 0, done2_cnt = 0;
  bit mac_pend = 0;
  int mac_cnt = 0;
  bit prev_wait = 0;
  logic       p_sel;
  logic [2:0] p_row, p_col;
  int ev_q[$];
  int ev2_q[$];
  int exp_q[$];

  function automatic int ev(input int ty, input int r, input int c, input int f);
    return (ty << 16) | (r << 8) | (c << 4) | f;
  endfunction

  // Expected event stream: for each C tile, A/B loads and a MAC per k, then the store.
  task automatic build_exp(input int m, input int t);
    exp_q.delete();
    for (int i = 0; i < m; i += t) begin
      for (int j = 0; j < m; j += t) begin
        for (int k = 0; k < m; k += t) begin
          exp_q.push_back(ev(1, i, k, 0));
          exp_q.push_back(ev(2, k, j, 0));
          exp_q.push_back(ev(3, 0, 0, (k == 0) ? 1 : 0));
        end
        exp_q.push_back(ev(4, i, j, 0));
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_events(input string tag, input int got[$]);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int n = 0; n < exp_q.size() && n < got.size(); n++)
      chk({tag, "_ev"}, got[n], exp_q[n]);
  endtask

  always @(negedge clk) begin
    start_n = 1'b0;
    if (reset) begin
      ld_ready  = 1'b0;
      st_ready  = 1'b0;
      mac_done  = 1'b0;
      mac_pend  = 0;
      prev_wait = 0;
    end else begin
      if (prev_wait && (!ld_valid || ld_sel !== p_sel || ld_row !== p_row || ld_col !== p_col))
        hold_err++;
      if (ld_valid) begin
        if (stall_cnt > 0) begin
          ld_ready = 1'b0;
          stall_cnt--;
          stall_seen++;
          if (ld_sel !== 1'b0 || ld_row !== 3'd0 || ld_col !== 3'd0) stall_bad++;
        end else begin
          ld_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
      end else begin
        ld_ready = 1'($urandom_range(0, 1));
      end
      prev_wait = ld_valid && !ld_ready;
      p_sel = ld_sel;
      p_row = ld_row;
      p_col = ld_col;
      if (ld_valid && ld_ready)
        ev_q.push_back(ev(ld_sel ? 2 : 1, int'(ld_row), int'(ld_col), 0));

      mac_done = 1'b0;
      if (mac_pend) begin
        mac_cnt--;
        if (mac_cnt == 0) begin
          mac_done = 1'b1;
          mac_pend = 0;
        end
      end
      if (mac_start) begin
        ev_q.push_back(ev(3, 0, 0, int'(acc_clr)));
        mac_pend = 1;
        mac_cnt  = rnd ? int'($urandom_range(1, 4)) : 1;
      end
      if (noise && ld_valid && ld_sel) mac_done = 1'b1;

      if (st_valid) begin
        if (st_block && n_st >= 1) st_ready = 1'b0;
        else st_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (st_ready) begin
          ev_q.push_back(ev(4, int'(st_row), int'(st_col), 0));
          n_st++;
        end
        if (noise && !sn_done) begin
          start_n = 1'b1;
          sn_done = 1;
        end
      end else begin
        st_ready = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ld_valid2) ev2_q.push_back(ev(ld_sel2 ? 2 : 1, int'(ld_row2), int'(ld_col2), 0));
      if (mac_start2) ev2_q.push_back(ev(3, 0, 0, int'(acc_clr2)));
      if (st_valid2) ev2_q.push_back(ev(4, int'(st_row2), int'(st_col2), 0));
      if (done2) done2_cnt++;
    end
  end

  // One full multiply on the 8x8 instance; exp_cycles counts LOAD_A..DONE inclusive (<0 skips).
  task automatic run_full(input string tag, input int exp_cycles);
    int s;
    bit seen;
    ev_q.delete();
    done_cnt = 0;
    n_st     = 0;
    sn_done  = 0;
    @(negedge clk); #1;
    start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    s = cyc;
    chk({tag, "_first_ld_valid"}, 32'(ld_valid), 1);
    chk({tag, "_busy"}, 32'(busy), 1);
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (done_cnt > 0) seen = 1;
      else begin
        @(negedge clk); #1;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    if (exp_cycles >= 0) chk({tag, "_cycles"}, done_cyc - s + 1, exp_cycles);
    @(negedge clk); #1;
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_done_pulse"}, done_cnt, 1);
    check_events(tag, ev_q);
  endtask

  initial begin
    bit found;
    reset     = 1'b1;
    start_i   = 1'b0;
    abort     = 1'b0;
    start2    = 1'b0;
    ld_ready2 = 1'b1;
    mac_done2 = 1'b1;
    st_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ld_valid", 32'(ld_valid), 0);
    chk("rst_mac_start", 32'(mac_start), 0);
    chk("rst_st_valid", 32'(st_valid), 0);
    chk("rst_idx", 32'({ld_row, ld_col, st_row, st_col}), 0);
    reset = 1'b0;

    // Zero-wait pass: 8 k-steps of 4 cycles, 4 stores, 1 DONE.
    build_exp(8, 4);
    run_full("s1", 37);

    // Five-cycle stall on the very first A load.
    stall_cnt  = 5;
    stall_seen = 0;
    stall_bad  = 0;
    run_full("s2", 42);
    chk("s2_stall_cycles", stall_seen, 5);
    chk("s2_stall_fields", stall_bad, 0);

    // Random backpressure plus stray mac_done in LOAD_B and a stray start mid-run.
    rnd   = 1;
    noise = 1;
    run_full("s3", -1);
    noise = 0;
    run_full("s3b", -1);
    chk("hold_stable", hold_err, 0);

    // Abort while the second store is stalled.
    rnd      = 0;
    st_block = 1;
    ev_q.delete();
    done_cnt = 0;
    n_st     = 0;
    @(negedge clk); #1;
    start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      if (st_valid && !st_ready && n_st == 1) found = 1;
      else begin
        @(negedge clk); #1;
      end
    end
    chk("s4_second_store", 32'(found), 1);
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    chk("s4_busy", 32'(busy), 0);
    chk("s4_st_valid", 32'(st_valid), 0);
    repeat (20) @(negedge clk);
    #1;
    chk("s4_no_done", done_cnt, 0);
    st_block = 0;
    run_full("s4_restart", 37);

    // Asynchronous reset between edges while waiting on the MAC.
    rnd = 1;
    @(negedge clk); #1;
    start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      if (mac_start) found = 1;
      else begin
        @(negedge clk); #1;
      end
    end
    chk("s5_mac_issue", 32'(found), 1);
    @(posedge clk);
    #2;
    chk("s5_busy_pre", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("s5_busy", 32'(busy), 0);
    chk("s5_strobes", 32'({ld_valid, mac_start, acc_clr, st_valid, done}), 0);
    @(negedge clk); #1;
    reset = 1'b0;
    run_full("s5_clean", -1);
    chk("hold_stable_2", hold_err, 0);

    // Single-tile matrix on the 4x4 instance.
    ev2_q.delete();
    done2_cnt = 0;
    @(negedge clk); #1;
    start2 = 1'b1;
    @(negedge clk); #1;
    start2 = 1'b0;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (done2_cnt > 0) found = 1;
      else begin
        @(negedge clk); #1;
      end
    end
    chk("s6_done_seen", 32'(found), 1);
    @(negedge clk); #1;
    chk("s6_busy_after", 32'(busy2), 0);
    chk("s6_done_pulse", done2_cnt, 1);
    build_exp(4, 4);
    check_events("s6", ev2_q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
